dec_exc_update: RTL and testbench

- Decoder-side counterpart of the encoder target-update math.
- Reconstructs the subframe excitation in place: exc[i] = round(L_shl(L_mac(L_mult(exc[i], gain_pit), code[i], gain_code), 1)) for i = 0..L_SUBFR-1.
- Sits under the decoder top-level FSM and is started once per subframe after gain decoding.
- Reads exc/code from scratch memory and writes exc back; ITU basic-op arithmetic is internal.

---
 rtl/dec_exc_update_if.sv | 28 ++
 rtl/dec_exc_update.sv | 167 ++++++++++++++++
 tb/tb_dec_exc_update.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_exc_update_if.sv
// Scratch-memory bus between dec_exc_update and the decoder scratch RAM.
// The master issues reads/writes; the slave returns read data one cycle later.
interface dec_exc_update_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] memIn;
    logic [ADDR_W-1:0] memReadAddr;
    logic [ADDR_W-1:0] memWriteAddr;
    logic [DATA_W-1:0] memOut;
    logic              memWriteEn;

    modport master (
        input  memIn,
        output memReadAddr,
        output memWriteAddr,
        output memOut,
        output memWriteEn
    );

    modport slave (
        output memIn,
        input  memReadAddr,
        input  memWriteAddr,
        input  memOut,
        input  memWriteEn
    );
endinterface

// File: rtl/dec_exc_update.sv
// Decoder excitation update: exc[i] = round(L_shl(L_mac(L_mult(exc[i],gp),
// code[i], gc), 1)), done in place in scratch memory, one sample per 6 cycles.
module dec_exc_update #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] exc_addr,
    input  logic [ADDR_W-1:0] code_addr,
    input  logic [15:0]       gain_pit,
    input  logic [15:0]       gain_code,
    input  logic [15:0]       L_SUBFR,
    dec_exc_update_if.master  mem,
    output logic              done
);

    typedef enum logic [2:0] {
        INIT,
        FOR_CHECK,
        RD_CODE,
        MULT,
        MAC,
        WRITE,
        INC,
        DONE
    } state_t;

    state_t            state_q;
    logic [15:0]       i_q;
    logic [15:0]       len_q;
    logic [15:0]       gp_q;
    logic [15:0]       gc_q;
    logic [ADDR_W-1:0] ea_q;
    logic [ADDR_W-1:0] ca_q;
    logic [15:0]       exc_q;
    logic [15:0]       code_q;
    logic [31:0]       ltemp_q;

    // Saturating 32-bit add: overflow only when operand signs agree
    // and the sum's sign differs from them.
    function automatic logic [31:0] l_add(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        if (a[31] == b[31] && s[31] != a[31])
            return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s;
    endfunction

    // 2*a*b; the only overflow case is (-1)*(-1) in Q15.
    function automatic logic [31:0] l_mult(input logic [15:0] a,
                                           input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        if (p == 32'sh4000_0000)
            return 32'h7FFF_FFFF;
        return {p[30:0], 1'b0};
    endfunction

    // Left shift by one, saturating when bit 30 would become the sign.
    function automatic logic [31:0] l_shl1(input logic [31:0] x);
        if (x[31] != x[30])
            return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {x[30:0], 1'b0};
    endfunction

    logic [31:0] shl_w;
    logic [31:0] rnd_w;
    logic [15:0] res_w;
    logic        unused_mem_hi;

    assign shl_w = l_shl1(ltemp_q);
    assign rnd_w = l_add(shl_w, 32'h0000_8000);
    assign res_w = rnd_w[31:16];
    assign unused_mem_hi = ^mem.memIn[DATA_W-1:16];

    // Sequencer: latches the job on start, then walks the 6-cycle
    // read-exc / read-code / mult / mac / write / increment loop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            i_q     <= '0;
            len_q   <= '0;
            gp_q    <= '0;
            gc_q    <= '0;
            ea_q    <= '0;
            ca_q    <= '0;
            exc_q   <= '0;
            code_q  <= '0;
            ltemp_q <= '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    i_q <= '0;
                    if (start) begin
                        gp_q    <= gain_pit;
                        gc_q    <= gain_code;
                        ea_q    <= exc_addr;
                        ca_q    <= code_addr;
                        len_q   <= L_SUBFR;
                        state_q <= FOR_CHECK;
                    end
                end
                FOR_CHECK: begin
                    state_q <= (i_q < len_q) ? RD_CODE : DONE;
                end
                RD_CODE: begin
                    exc_q   <= mem.memIn[15:0];
                    state_q <= MULT;
                end
                MULT: begin
                    code_q  <= mem.memIn[15:0];
                    ltemp_q <= l_mult(exc_q, gp_q);
                    state_q <= MAC;
                end
                MAC: begin
                    ltemp_q <= l_add(ltemp_q, l_mult(code_q, gc_q));
                    state_q <= WRITE;
                end
                WRITE: begin
                    state_q <= INC;
                end
                INC: begin
                    i_q     <= i_q + 16'd1;
                    state_q <= FOR_CHECK;
                end
                DONE: begin
                    state_q <= INIT;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    // Bus outputs decode directly from the state; idle value is zero.
    always_comb begin
        mem.memReadAddr  = '0;
        mem.memWriteAddr = '0;
        mem.memOut       = '0;
        mem.memWriteEn   = 1'b0;
        done             = 1'b0;
        unique case (state_q)
            FOR_CHECK: begin
                if (i_q < len_q)
                    mem.memReadAddr = ea_q + i_q[ADDR_W-1:0];
            end
            RD_CODE: begin
                mem.memReadAddr = ca_q + i_q[ADDR_W-1:0];
            end
            WRITE: begin
                mem.memWriteAddr = ea_q + i_q[ADDR_W-1:0];
                mem.memOut       = {{(DATA_W-16){res_w[15]}}, res_w};
                mem.memWriteEn   = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dec_exc_update.sv
// Bench for dec_exc_update: scratch RAM model, write/done monitor,
// and scoreboard of expected writes per subframe.
module tb_dec_exc_update;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] exc_addr;
    logic [11:0] code_addr;
    logic [15:0] gain_pit;
    logic [15:0] gain_code;
    logic [15:0] L_SUBFR;
    logic        done;

    dec_exc_update_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dec_exc_update #(.ADDR_W(12), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .exc_addr  (exc_addr),
        .code_addr (code_addr),
        .gain_pit  (gain_pit),
        .gain_code (gain_code),
        .L_SUBFR   (L_SUBFR),
        .mem       (bus.master),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    logic [31:0] ram [4096];
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int          done_q[$];
    int          cyc = 0;
    int          t0 = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clock) begin
        bus.memIn <= ram[bus.memReadAddr];
        cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (bus.memWriteEn)
            obs_q.push_back('{bus.memWriteAddr, bus.memOut, cyc - t0});
        if (done)
            done_q.push_back(cyc - t0);
    end

    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic logic [31:0] model(input logic [15:0] e,
                                          input logic [15:0] c,
                                          input logic [15:0] gp,
                                          input logic [15:0] gc);
        longint      t;
        logic [63:0] r;
        t = sat(2 * longint'($signed(e)) * longint'($signed(gp)));
        t = sat(t + sat(2 * longint'($signed(c)) * longint'($signed(gc))));
        t = sat(t * 2);
        r = sat(t + 32768);
        return {{16{r[31]}}, r[31:16]};
    endfunction

    task automatic push_model(input logic [11:0] ea, input logic [11:0] ca,
                              input logic [15:0] gp, input logic [15:0] gc,
                              input int n);
        for (int k = 0; k < n; k++) begin
            logic [11:0] a;
            logic [11:0] b;
            a = ea + 12'(k);
            b = ca + 12'(k);
            exp_q.push_back('{a, model(ram[a][15:0], ram[b][15:0], gp, gc),
                              5 + 6 * k});
        end
    endtask

    // Drives one subframe (start held two cycles: the second falls in
    // FOR_CHECK and must be ignored), scrambles inputs, waits for done,
    // then checks done timing and the write stream against exp_q.
    task automatic run_subframe(input string nm,
                                input logic [11:0] ea, input logic [11:0] ca,
                                input logic [15:0] gp, input logic [15:0] gc,
                                input logic [15:0] len);
        int  lim;
        bit  to;
        wr_t e;
        wr_t o;
        obs_q.delete();
        done_q.delete();
        exc_addr = ea;
        code_addr = ca;
        gain_pit = gp;
        gain_code = gc;
        L_SUBFR = len;
        t0 = cyc;
        start = 1'b1;
        @(negedge clock);
        exc_addr = 12'($urandom);
        code_addr = 12'($urandom);
        gain_pit = 16'($urandom);
        gain_code = 16'($urandom);
        L_SUBFR = 16'($urandom);
        @(negedge clock);
        start = 1'b0;
        lim = 6 * int'(len) + 20;
        to = 1'b1;
        for (int k = 0; k < lim; k++) begin
            if (done_q.size() != 0) begin
                to = 1'b0;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        n_checks++;
        if (to) begin
            n_errors++;
            $display("FAIL %s timeout: no done within %0d cycles", nm, lim);
        end else begin
            n_checks++;
            if (done_q.size() != 1 || done_q[0] !== 2 + 6 * int'(len)) begin
                n_errors++;
                $display("FAIL %s done: got %0d pulses first at cycle %0d, want 1 at %0d",
                         nm, done_q.size(), done_q[0], 2 + 6 * int'(len));
            end
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s write count: got %0d want %0d",
                     nm, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
                n_errors++;
                $display("FAIL %s write: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                         nm, o.a, o.d, o.c, e.a, e.d, e.c);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        exc_addr = '0;
        code_addr = '0;
        gain_pit = '0;
        gain_code = '0;
        L_SUBFR = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.memReadAddr !== 12'h0 || bus.memWriteAddr !== 12'h0 ||
            bus.memOut !== 32'h0 || bus.memWriteEn !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset outputs: ra=%h wa=%h d=%h we=%b done=%b want all 0",
                     bus.memReadAddr, bus.memWriteAddr, bus.memOut,
                     bus.memWriteEn, done);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        ram[12'h100] = 32'h0000_1000;
        ram[12'h200] = 32'h0000_2000;
        exp_q.push_back('{12'h100, 32'h0000_1400, 5});
        run_subframe("single", 12'h100, 12'h200, 16'h4000, 16'h0800, 16'd1);
    endtask

    task automatic test_saturate();
        ram[12'h110] = 32'h0000_8000;
        ram[12'h210] = 32'h0000_7FFF;
        exp_q.push_back('{12'h110, 32'h0000_7FFF, 5});
        run_subframe("saturate", 12'h110, 12'h210, 16'h8000, 16'h7FFF, 16'd1);
    endtask

    task automatic test_negative();
        ram[12'h120] = 32'hABCD_F000;
        ram[12'h220] = 32'h5555_0000;
        exp_q.push_back('{12'h120, 32'hFFFF_F000, 5});
        run_subframe("negative", 12'h120, 12'h220, 16'h4000, 16'h1234, 16'd1);
    endtask

    task automatic test_zero_len();
        run_subframe("zero_len", 12'h130, 12'h230, 16'h4000, 16'h4000, 16'd0);
    endtask

    task automatic test_wrap();
        logic [15:0] gp;
        logic [15:0] gc;
        for (int k = 0; k < 40; k++) begin
            ram[12'hFF0 + 12'(k)] = $urandom;
            ram[12'h300 + 12'(k)] = $urandom;
        end
        ram[12'hFF0] = 32'h0000_8000;
        gp = 16'($urandom);
        gc = 16'($urandom);
        push_model(12'hFF0, 12'h300, gp, gc, 40);
        run_subframe("wrap40", 12'hFF0, 12'h300, gp, gc, 16'd40);
    endtask

    // Reset lands while sample 5 is in MAC; only samples 0..4 may be
    // written and no done may follow.
    task automatic test_abort();
        wr_t e;
        wr_t o;
        for (int k = 0; k < 10; k++) begin
            ram[12'h400 + 12'(k)] = $urandom;
            ram[12'h500 + 12'(k)] = $urandom;
        end
        push_model(12'h400, 12'h500, 16'h3A5C, 16'h0123, 5);
        obs_q.delete();
        done_q.delete();
        exc_addr = 12'h400;
        code_addr = 12'h500;
        gain_pit = 16'h3A5C;
        gain_code = 16'h0123;
        L_SUBFR = 16'd10;
        t0 = cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc - t0 < 34) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.memReadAddr !== 12'h0 || bus.memWriteEn !== 1'b0 ||
            bus.memOut !== 32'h0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort outputs: ra=%h we=%b d=%h done=%b want all 0",
                     bus.memReadAddr, bus.memWriteEn, bus.memOut, done);
        end
        reset = 1'b0;
        repeat (70) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 5 || done_q.size() != 0) begin
            n_errors++;
            $display("FAIL abort counts: got %0d writes %0d done, want 5 writes 0 done",
                     obs_q.size(), done_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
                n_errors++;
                $display("FAIL abort write: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                         o.a, o.d, o.c, e.a, e.d, e.c);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            ram[12'h600 + 12'(k)] = $urandom;
            ram[12'h700 + 12'(k)] = $urandom;
        end
        push_model(12'h600, 12'h700, 16'h7FFF, 16'h8000, 3);
        run_subframe("after_abort", 12'h600, 12'h700, 16'h7FFF, 16'h8000, 16'd3);
        push_model(12'h600, 12'h700, 16'hC000, 16'h2000, 2);
        run_subframe("back_to_back", 12'h600, 12'h700, 16'hC000, 16'h2000, 16'd2);
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) ram[k] = '0;
        test_reset();
        test_single();
        test_saturate();
        test_negative();
        test_zero_len();
        test_wrap();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
